lifo_stack: RTL and testbench
=============================

LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits (legal 1..32).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of stack entries (legal 2..256).
REQ-003 The block SHALL have parameter CW = $clog2(DEPTH+1), meaning width of the occupancy count (derived, not overridden).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 push  input  1  request to push din this cycle.
REQ-007 pop  input  1  request to pop the top entry this cycle.
REQ-008 clear  input  1  synchronous empty-stack and error-clear command.
REQ-009 din  input  WIDTH  data to push.
REQ-010 dout  output  WIDTH  current top-of-stack word; 0 when empty.
REQ-011 count  output  CW  number of valid entries, 0..DEPTH.
REQ-012 empty  output  1  high when count == 0.
REQ-013 full  output  1  high when count == DEPTH.
REQ-014 overflow  output  1  sticky: push was rejected because stack was full.
REQ-015 underflow  output  1  sticky: pop was rejected because stack was empty.

Function
REQ-016 Storage SHALL be DEPTH x WIDTH registers addressed by count; top entry is index count-1.
REQ-017 Operation per rising edge SHALL be decoded in priority: clear, then {push,pop} combination.
REQ-018 clear=1: count->0, overflow->0, underflow->0, push/pop ignored that cycle; memory contents need not be cleared.
REQ-019 push=1, pop=0, !full: mem[count]<=din, count->count+1.
REQ-020 push=1, pop=0, full: no storage or count change, overflow->1.
REQ-021 push=0, pop=1, !empty: count->count-1; popped word is the dout value visible in the cycle the pop is sampled.
REQ-022 push=0, pop=1, empty: no change, underflow->1.
REQ-023 push=1, pop=1, !empty (including full): replace-top, mem[count-1]<=din, count unchanged, no flag set.
REQ-024 push=1, pop=1, empty: treated as plain push (count->1), underflow not set.
REQ-025 dout SHALL be combinational from storage and count: mem[count-1] when count>0, else 0; updated value visible the cycle after the operating edge.
REQ-026 empty, full SHALL be combinational decodes of count; count never exceeds DEPTH and never wraps below 0.
REQ-027 overflow/underflow SHALL remain set until clear or reset; simultaneous clear and error condition leaves the flag 0.
REQ-028 Operation latency SHALL be one cycle; a new push/pop is accepted every cycle with no idle gap.

Reset
REQ-029 rst_n low SHALL asynchronously force count=0, overflow=0, underflow=0, hence empty=1, full=0, dout=0.
REQ-030 Reset asserted mid-sequence SHALL discard all entries; the first operation after release SHALL behave as on an empty stack.
REQ-031 Storage registers SHALL NOT require reset.

Verification (WIDTH=8, DEPTH=4)
REQ-032 Push 0x11,0x22,0x33 then pop x3 -> dout 0x33,0x22,0x11 before each pop, then empty=1, dout=0, count=0.
REQ-033 Push 0xA0..0xA3 (4 words), then push 0xFF -> full=1, count=4, overflow=1, dout=0xA3.
REQ-034 From empty, pop -> underflow=1, count=0; then clear -> underflow=0.
REQ-035 Stack holds 0x01,0x02; push+pop with din=0x55 -> count=2, dout=0x55; pop -> dout=0x01.
REQ-036 Push 0x77 twice, assert rst_n low between clock edges -> count=0, empty=1 immediately; after release push 0x99 -> count=1, dout=0x99.
REQ-037 From full stack, push+pop with din=0xEE each cycle for 3 cycles -> count stays 4, overflow stays 0, dout=0xEE.

Source files
------------

// File: rtl/lifo_stack.sv
// lifo_stack: register-based LIFO with combinational top-of-stack and sticky error flags
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top, wr_idx;
  logic             replace, we;
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign top     = AW'(count - CW'(1));
  assign dout    = empty ? '0 : mem[top];
  // push+pop on a non-empty stack overwrites the top word in place
  assign replace = push && pop && !empty;
  assign we      = !clear && push && (replace || !full);
  assign wr_idx  = replace ? top : AW'(count);
  always_ff @(posedge clk)
    if (we) mem[wr_idx] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (replace) begin
      count <= count;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (push) begin
      overflow <= 1'b1;
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end else if (pop) begin
      underflow <= 1'b1;
    end
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed vectors with hand-computed expectations for lifo_stack (WIDTH=8, DEPTH=4)
module tb_lifo_stack;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0, pop = 1'b0, clear = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic [2:0] count;
  logic       empty, full, overflow, underflow;
  int         n_vec = 0, n_bad = 0;

  lifo_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clear(clear), .din(din),
    .dout(dout), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic c, input logic [7:0] d);
    push = p;
    pop = q;
    clear = c;
    din = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // push three, pop three
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    chk("p3_count", count, 3);
    chk("pop1_dout", dout, 8'h33);
    step(0, 1, 0, 0);
    chk("pop2_dout", dout, 8'h22);
    step(0, 1, 0, 0);
    chk("pop3_dout", dout, 8'h11);
    step(0, 1, 0, 0);
    chk("drain_empty", empty, 1);
    chk("drain_dout", dout, 0);
    chk("drain_count", count, 0);
    chk("drain_unf", underflow, 0);
    // fill to full then overflow
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'hA0 + 8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    chk("fill_ovf", overflow, 0);
    step(1, 0, 0, 8'hFF);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_dout", dout, 8'hA3);
    step(0, 1, 0, 0);
    chk("ovf_pop_dout", dout, 8'hA2);
    chk("ovf_sticky", overflow, 1);
    // clear with push: push ignored, flags cleared
    step(1, 0, 1, 8'h42);
    chk("clr_count", count, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_dout", dout, 0);
    // underflow then clear coinciding with another bad pop
    step(0, 1, 0, 0);
    chk("unf_flag", underflow, 1);
    chk("unf_count", count, 0);
    step(0, 0, 0, 0);
    chk("unf_sticky", underflow, 1);
    step(0, 1, 1, 0);
    chk("clr_unf", underflow, 0);
    // replace-top
    step(1, 0, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    step(1, 1, 0, 8'h55);
    chk("rep_count", count, 2);
    chk("rep_dout", dout, 8'h55);
    step(0, 1, 0, 0);
    chk("rep_pop_dout", dout, 8'h01);
    chk("rep_pop_count", count, 1);
    step(0, 1, 0, 0);
    // push+pop on empty acts as push
    step(1, 1, 0, 8'h5A);
    chk("pp_empty_count", count, 1);
    chk("pp_empty_dout", dout, 8'h5A);
    chk("pp_empty_unf", underflow, 0);
    step(0, 0, 1, 0);
    // async reset mid-sequence
    step(1, 0, 0, 8'h77);
    step(1, 0, 0, 8'h77);
    chk("pre_rst_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 8'h99);
    chk("post_rst_count", count, 1);
    chk("post_rst_dout", dout, 8'h99);
    step(0, 0, 1, 0);
    // replace-top on a full stack, back to back
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 8'(i));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 8'hEE);
      chk("full_rep_count", count, 4);
      chk("full_rep_ovf", overflow, 0);
      chk("full_rep_dout", dout, 8'hEE);
    end
    step(0, 1, 0, 0);
    chk("full_rep_pop", dout, 8'h03);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
